// File: rtl/aes_ctrl_nr.sv
// AES round controller: sequences datapath, S-box and key generator for AESENC,
// AESENCLAST, AESKEYGENASSIST and AESENCFULL. Optional abort input: AES_CTRL_ABORT_EN.
package aes_pkg;
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;
endpackage

module aes_ctrl_nr #(
  parameter int KEY_BITS = 128
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start_i,
  input  aes_pkg::opcode opcode_i,
`ifdef AES_CTRL_ABORT_EN
  input  logic           abort_i,
`endif
  output logic           ready_o,
  output logic           busy_o,
  output logic           full_enc_o,
  output logic           zero_rnd_o,
  output logic           key_sel_o,
  output logic           final_rnd_o,
  output logic           key_sub_o,
  output logic           gen_key_o,
  output logic           next_rnd_o,
  output logic           key_odd_o,
  output logic [3:0]     rnd_num_o,
  output logic [7:0]     r_con_o,
  output logic           cipher_ready_o,
  output logic           key_ready_o
);
  import aes_pkg::*;

  localparam int         NR    = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_L  = 4'(NR);
  localparam bit         IS256 = (KEY_BITS == 256);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_ctrl_nr: KEY_BITS must be 128 or 256");
  end

  // Handshake: a request is taken on a rising edge where ready_o && start_i &&
  // opcode_i != NOOP; ready_o is high exactly in IDLE and start_i is ignored elsewhere.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SBOX   = 2'd1,
    ROUND  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  opcode      op_q, op_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] rc_q, rc_d;
  logic       abort;

`ifdef AES_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= NOOP;
      rnd_q   <= 4'd0;
      rc_q    <= 8'h01;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rnd_q   <= rnd_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rnd_d   = rnd_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (opcode_i)
            AESENC, AESENCLAST: begin
              state_d = SBOX;
              op_d    = opcode_i;
            end
            AESKEYGENASSIST: begin
              state_d = ROUND;
              op_d    = opcode_i;
            end
            AESENCFULL: begin
              state_d = SBOX;
              op_d    = opcode_i;
              rnd_d   = 4'd0;
              rc_d    = 8'h01;
            end
            default: ;
          endcase
        end
      end
      SBOX: begin
        case (op_q)
          AESENC, AESENCLAST: state_d = ROUND;
          AESENCFULL: begin
            state_d = ROUND;
            rnd_d   = rnd_q + 4'd1;
          end
          default: begin
            state_d = IDLE;
            op_d    = NOOP;
          end
        endcase
      end
      ROUND: begin
        case (op_q)
          AESENC, AESENCLAST, AESKEYGENASSIST: state_d = FINISH;
          AESENCFULL: begin
            if (rnd_q == NR_L) begin
              state_d = FINISH;
            end else begin
              state_d = SBOX;
              // AES-256 expands a new Rcon only every second round key
              if (!IS256 || !rnd_q[0]) rc_d = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
            end
          end
          default: begin
            state_d = IDLE;
            op_d    = NOOP;
          end
        endcase
      end
      FINISH: begin
        state_d = IDLE;
        op_d    = NOOP;
      end
      default: begin
        state_d = IDLE;
        op_d    = NOOP;
      end
    endcase
    if (abort && (state_q == SBOX || state_q == ROUND)) begin
      state_d = IDLE;
      op_d    = NOOP;
      rnd_d   = 4'd0;
      rc_d    = 8'h01;
    end
  end

  always_comb begin
    ready_o        = (state_q == IDLE);
    busy_o         = (state_q != IDLE);
    full_enc_o     = 1'b1;
    zero_rnd_o     = 1'b0;
    key_sel_o      = 1'b0;
    final_rnd_o    = 1'b1;
    key_sub_o      = 1'b0;
    gen_key_o      = 1'b0;
    next_rnd_o     = 1'b0;
    key_odd_o      = 1'b0;
    rnd_num_o      = rnd_q;
    r_con_o        = rc_q;
    cipher_ready_o = 1'b0;
    key_ready_o    = 1'b0;
    case (state_q)
      SBOX: begin
        if (op_q == AESENCFULL) begin
          // AES-256 round 1 uses the upper key half as-is
          gen_key_o  = !(IS256 && rnd_q == 4'd1);
          zero_rnd_o = (rnd_q == 4'd0);
          key_sel_o  = (rnd_q == 4'd0);
          key_odd_o  = IS256 & rnd_q[0];
        end
      end
      ROUND: begin
        case (op_q)
          AESENC: begin
            full_enc_o  = 1'b1;
            final_rnd_o = 1'b0;
            zero_rnd_o  = 1'b1;
            key_sel_o   = 1'b1;
          end
          AESENCLAST: begin
            full_enc_o  = 1'b0;
            final_rnd_o = 1'b1;
            zero_rnd_o  = 1'b1;
            key_sel_o   = 1'b0;
          end
          AESKEYGENASSIST: begin
            key_sub_o = 1'b1;
            gen_key_o = 1'b0;
          end
          AESENCFULL: begin
            full_enc_o  = 1'b0;
            zero_rnd_o  = 1'b1;
            key_sub_o   = 1'b1;
            next_rnd_o  = 1'b1;
            final_rnd_o = (rnd_q == NR_L);
            key_odd_o   = IS256 & rnd_q[0];
          end
          default: ;
        endcase
      end
      FINISH: begin
        if (op_q == AESKEYGENASSIST) key_ready_o = 1'b1;
        else cipher_ready_o = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_ctrl_nr.sv
// Bench for aes_ctrl_nr: AES-128 and AES-256 instances driven in lockstep, each
// checked every cycle against a per-operation expected output trace.
module tb_aes_ctrl_nr;
  import aes_pkg::*;

  localparam int W = 24;

  // ---------------- clock / reset ----------------
  logic  clk = 1'b0;
  logic  nrst = 1'b0;
  logic  start = 1'b0;
  opcode op_in = NOOP;
`ifdef AES_CTRL_ABORT_EN
  logic  abort = 1'b0;
`endif
  always #5 clk = ~clk;

  logic [1:0] ready, busy, full_enc, zero_rnd, key_sel, final_rnd, key_sub;
  logic [1:0] gen_key, next_rnd, key_odd, c_rdy, k_rdy;
  logic [3:0] rnd0, rnd1;
  logic [7:0] rc0, rc1;

  aes_ctrl_nr #(.KEY_BITS(128)) u128 (
    .clk(clk), .nrst(nrst), .start_i(start), .opcode_i(op_in),
`ifdef AES_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(ready[0]), .busy_o(busy[0]), .full_enc_o(full_enc[0]),
    .zero_rnd_o(zero_rnd[0]), .key_sel_o(key_sel[0]), .final_rnd_o(final_rnd[0]),
    .key_sub_o(key_sub[0]), .gen_key_o(gen_key[0]), .next_rnd_o(next_rnd[0]),
    .key_odd_o(key_odd[0]), .rnd_num_o(rnd0), .r_con_o(rc0),
    .cipher_ready_o(c_rdy[0]), .key_ready_o(k_rdy[0]));

  aes_ctrl_nr #(.KEY_BITS(256)) u256 (
    .clk(clk), .nrst(nrst), .start_i(start), .opcode_i(op_in),
`ifdef AES_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(ready[1]), .busy_o(busy[1]), .full_enc_o(full_enc[1]),
    .zero_rnd_o(zero_rnd[1]), .key_sel_o(key_sel[1]), .final_rnd_o(final_rnd[1]),
    .key_sub_o(key_sub[1]), .gen_key_o(gen_key[1]), .next_rnd_o(next_rnd[1]),
    .key_odd_o(key_odd[1]), .rnd_num_o(rnd1), .r_con_o(rc1),
    .cipher_ready_o(c_rdy[1]), .key_ready_o(k_rdy[1]));

  // {ready,busy,full,zero,ksel,final,ksub,gen,next,odd,rnd[3:0],rc[7:0],crdy,krdy}
  logic [W-1:0] obs0, obs1;
  assign obs0 = {ready[0], busy[0], full_enc[0], zero_rnd[0], key_sel[0], final_rnd[0],
                 key_sub[0], gen_key[0], next_rnd[0], key_odd[0], rnd0, rc0, c_rdy[0], k_rdy[0]};
  assign obs1 = {ready[1], busy[1], full_enc[1], zero_rnd[1], key_sel[1], final_rnd[1],
                 key_sub[1], gen_key[1], next_rnd[1], key_odd[1], rnd1, rc1, c_rdy[1], k_rdy[1]};

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [3:0]   m_rnd [2] = '{4'd0, 4'd0};
  logic [7:0]   m_rc  [2] = '{8'h01, 8'h01};
  logic [3:0]   idle_rnd [2] = '{4'd0, 4'd0};
  logic [7:0]   idle_rc  [2] = '{8'h01, 8'h01};
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  function automatic logic [W-1:0] mk(bit bsy, bit full, bit zero, bit ksel, bit fin,
                                      bit ksub, bit gen, bit nxt, bit odd,
                                      logic [3:0] rnd, logic [7:0] rc, bit crdy, bit krdy);
    return {~bsy, bsy, full, zero, ksel, fin, ksub, gen, nxt, odd, rnd, rc, crdy, krdy};
  endfunction

  // Rcon used by full-encryption round r (1-based) from the key schedule table
  function automatic logic [7:0] rcon_of(int r, bit is256);
    return is256 ? rcon_tab[(r - 1) / 2] : rcon_tab[r - 1];
  endfunction

  task automatic push(int d, logic [W-1:0] v);
    if (d == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic model_op(int d, opcode o);
    int nr;
    bit is256;
    is256 = (d == 1);
    nr = is256 ? 14 : 10;
    case (o)
      AESENC: begin
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 0, 0));
        push(d, mk(1, 1, 1, 1, 0, 0, 0, 0, 0, m_rnd[d], m_rc[d], 0, 0));
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 1, 0));
      end
      AESENCLAST: begin
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 0, 0));
        push(d, mk(1, 0, 1, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 0, 0));
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 1, 0));
      end
      AESKEYGENASSIST: begin
        push(d, mk(1, 1, 0, 0, 1, 1, 0, 0, 0, m_rnd[d], m_rc[d], 0, 0));
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, m_rnd[d], m_rc[d], 0, 1));
      end
      AESENCFULL: begin
        for (int r = 1; r <= nr; r++) begin
          push(d, mk(1, 1, r == 1, r == 1, 1, 0, !(is256 && r == 2), 0,
                     is256 && ((r - 1) % 2 == 1), 4'(r - 1), rcon_of(r, is256), 0, 0));
          push(d, mk(1, 0, 1, 0, r == nr, 1, 0, 1, is256 && (r % 2 == 1),
                     4'(r), rcon_of(r, is256), 0, 0));
        end
        push(d, mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 4'(nr), rcon_of(nr, is256), 1, 0));
        m_rnd[d] = 4'(nr);
        m_rc[d]  = rcon_of(nr, is256);
      end
      default: ;
    endcase
  endtask

  task automatic flush_model();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_rnd[d] = 4'd0;  m_rc[d] = 8'h01;
      idle_rnd[d] = 4'd0;  idle_rc[d] = 8'h01;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(int d, logic [W-1:0] act);
    logic [W-1:0] want;
    bit have;
    have = 1'b1;
    want = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, idle_rnd[d], idle_rc[d], 0, 0);
    if (act[22]) begin
      if (d == 0) begin
        if (exp_q0.size() > 0) want = exp_q0.pop_front(); else have = 1'b0;
      end else begin
        if (exp_q1.size() > 0) want = exp_q1.pop_front(); else have = 1'b0;
      end
      idle_rnd[d] = want[13:10];
      idle_rc[d]  = want[9:2];
    end
    total++;
    if (!have) begin
      bad++;
      $display("FAIL unexpected_busy dut=%0d cycle=%0d got=%h want=idle", d, cyc, act);
    end else if (act !== want) begin
      bad++;
      $display("FAIL outputs dut=%0d cycle=%0d got=%h want=%h", d, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    check(0, obs0);
    check(1, obs1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (ready !== 2'b11) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL ready_timeout got=%b want=11", ready);
        break;
      end
    end
  endtask

  task automatic issue(opcode o, int gap);
    wait_ready();
    repeat (gap) begin @(posedge clk); #1; end
    start = 1'b1;
    op_in = o;
    if (o != NOOP) begin
      model_op(0, o);
      model_op(1, o);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op_in = NOOP;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;

    issue(AESENC, 0);

    // start held through the whole keygen op: only one accept
    wait_ready();
    start = 1'b1;
    op_in = AESKEYGENASSIST;
    model_op(0, AESKEYGENASSIST);
    model_op(1, AESKEYGENASSIST);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    op_in = NOOP;

    issue(AESENCFULL, 0);
    issue(AESENCLAST, 0);
    issue(AESENC, 0);

    // reset dropped during ROUND of round 5
    wait_ready();
    start = 1'b1;
    op_in = AESENCFULL;
    model_op(0, AESENCFULL);
    model_op(1, AESENCFULL);
    @(posedge clk); #1;
    start = 1'b0;
    op_in = NOOP;
    repeat (9) begin @(posedge clk); #1; end
    nrst = 1'b0;
    flush_model();
    repeat (2) begin @(posedge clk); #1; end
    nrst = 1'b1;
    issue(NOOP, 0);
    repeat (2) begin @(posedge clk); #1; end

`ifdef AES_CTRL_ABORT_EN
    // abort during ROUND of round 3, then a fresh full encryption
    issue(AESENCFULL, 0);
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush_model();
    issue(AESENCFULL, 1);
`endif

    for (int i = 0; i < 25; i++) begin
      issue(opcode'(3'($urandom_range(0, 4))), $urandom_range(0, 2));
    end

    wait_ready();
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d/%0d want=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
